dmem_arbiter: RTL and testbench

- Two-master arbiter in front of the single-port data memory.
- Shares the memory between the core load/store port (m0) and a debug/preload port (m1), e.g. bench loading or dumping dmem without hierarchical access.
- Bounded-burst round-robin arbitration. One access per cycle. Reads track one outstanding read and route the returned data back to the master that issued it.

---
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port dmem between the core port (m0) and a debug/preload port (m1).
// Latency: grant is combinational; writes complete at the grant edge; read data returns the cycle after the grant.
// Backpressure: a master holds req until it sees gnt; bounded-burst round robin. DMEM_ARB_PERF_EN adds stall counters.
module dmem_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [AWIDTH-1:0] m0_addr,
  input  logic [DWIDTH-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DWIDTH-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [AWIDTH-1:0] m1_addr,
  input  logic [DWIDTH-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DWIDTH-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       m0_stall_cnt,
  output logic [31:0]       m1_stall_cnt,
`endif
  output logic              busy
);

  // burst_cnt is 4 bits because MAX_BURST is limited to 1..15
  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic       last_owner;  // 0 = m0, 1 = m1
  logic [3:0] burst_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       gnt_any;
  logic       gnt_we;

  // Arbitration: a lone requester always wins; on a tie the previous owner keeps the
  // port only while it is mid-burst and under the limit. No grants while reset is held.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        if ((burst_cnt != 4'd0) && (burst_cnt < BURST_MAX)) begin
          m0_gnt = ~last_owner;
          m1_gnt = last_owner;
        end else begin
          m0_gnt = last_owner;
          m1_gnt = ~last_owner;
        end
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  assign gnt_any = m0_gnt | m1_gnt;

  // Memory strobe and mux from the granted master; all zero when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  assign gnt_we = mem_we;

  // Round-robin state: count consecutive grants to one owner, restart on handover or idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= 1'b1;
      burst_cnt  <= 4'd0;
    end else if (gnt_any) begin
      if (m1_gnt == last_owner) begin
        if (burst_cnt < BURST_MAX) begin
          burst_cnt <= burst_cnt + 4'd1;
        end
      end else begin
        last_owner <= m1_gnt;
        burst_cnt  <= 4'd1;
      end
    end else begin
      burst_cnt <= 4'd0;
    end
  end

  // Outstanding read tracker: one read in flight, tagged with the master that issued it.
  // A reset between grant and data drops the read so no rvalid is ever produced for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= gnt_any & ~gnt_we;
      if (gnt_any && !gnt_we) begin
        rd_owner <= m1_gnt;
      end
    end
  end

  assign m0_rvalid = rd_pend & ~rd_owner;
  assign m1_rvalid = rd_pend & rd_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;
  assign busy      = rst & (rd_pend | m0_req | m1_req);

`ifdef DMEM_ARB_PERF_EN
  logic m0_stall;
  logic m1_stall;

  assign m0_stall = rst & m0_req & ~m0_gnt;
  assign m1_stall = rst & m1_req & ~m1_gnt;

  // Saturating per-master stall counters: cycles spent requesting without a grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (m0_stall && (m0_stall_cnt != 32'hFFFF_FFFF)) begin
        m0_stall_cnt <= m0_stall_cnt + 32'd1;
      end
      if (m1_stall && (m1_stall_cnt != 32'hFFFF_FFFF)) begin
        m1_stall_cnt <= m1_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives both masters against a behavioural dmem and checks grants,
// memory drive and read routing; read data expectations come from a shadow of issued writes.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0]   m0_stall_cnt, m1_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
  typedef struct { bit m; logic [DW-1:0] d; } rd_t;

  txn_t q0[$];
  txn_t q1[$];
  rd_t  exp_q[$];
  int   gnt_log[$];

  dmem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_PERF_EN
    .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port dmem: synchronous write, registered read data
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Monitor / scoreboard, sampled mid-cycle
  logic [DW-1:0] shadow [16];
  rd_t           e;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          resp_now;
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
    end else if (!clk) begin
      resp_now = (exp_q.size() > 0);
      total++;
      if (resp_now) begin
        e = exp_q.pop_front();
        if (m0_rvalid !== !e.m || m1_rvalid !== e.m ||
            (e.m ? m1_rdata : m0_rdata) !== e.d || (e.m ? m0_rdata : m1_rdata) !== '0) begin
          bad++;
          $display("FAIL rd_resp: m0 rv=%b rd=%h m1 rv=%b rd=%h, want owner m%0d data %h",
                   m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, e.m, e.d);
        end
      end else if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== '0 || m1_rdata !== '0) begin
        bad++;
        $display("FAIL idle_resp: m0 rv=%b rd=%h m1 rv=%b rd=%h, want all 0",
                 m0_rvalid, m0_rdata, m1_rvalid, m1_rdata);
      end

      total++;
      if (busy !== (m0_req | m1_req | resp_now)) begin
        bad++;
        $display("FAIL busy: got %b want %b", busy, m0_req | m1_req | resp_now);
      end

      total++;
      if ((m0_gnt !== m0_req && !m1_req) || (m1_gnt !== m1_req && !m0_req) ||
          (m0_req && m1_req && (m0_gnt ^ m1_gnt) !== 1'b1)) begin
        bad++;
        $display("FAIL gnt_legal: req=%b%b gnt=%b%b", m1_req, m0_req, m1_gnt, m0_gnt);
      end

      if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
        exp_we    = m1_gnt ? m1_we    : m0_we;
        exp_addr  = m1_gnt ? m1_addr  : m0_addr;
        exp_wdata = m1_gnt ? m1_wdata : m0_wdata;
        total++;
        if (mem_en !== 1'b1 || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
          bad++;
          $display("FAIL mem_drive: en=%b we=%b a=%h d=%h want 1 %b %h %h",
                   mem_en, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wdata);
        end
        if (exp_we) shadow[exp_addr] = exp_wdata;
        else begin
          e.m = m1_gnt;
          e.d = shadow[exp_addr];
          exp_q.push_back(e);
        end
        gnt_log.push_back(m1_gnt ? 1 : 0);
      end else begin
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
          bad++;
          $display("FAIL mem_idle: en=%b we=%b a=%h d=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
        end
        gnt_log.push_back(-1);
      end
    end
  end

  // Each master presents the head of its queue and advances once it sees gnt.
  // Called and returns at 2 time units after a rising edge.
  task automatic run(input int budget);
    int  n = 0;
    bit  g0, g1;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      m0_req = (q0.size() > 0);
      m1_req = (q1.size() > 0);
      if (m0_req) begin m0_we = q0[0].we; m0_addr = q0[0].a; m0_wdata = q0[0].d; end
      else begin m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; end
      if (m1_req) begin m1_we = q1[0].we; m1_addr = q1[0].a; m1_wdata = q1[0].d; end
      else begin m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; end
      @(negedge clk);
      g0 = (m0_gnt === 1'b1);
      g1 = (m1_gnt === 1'b1);
      @(posedge clk);
      #2;
      if (g0) void'(q0.pop_front());
      if (g1) void'(q1.pop_front());
      n++;
    end
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    if (q0.size() > 0 || q1.size() > 0) begin
      total++;
      bad++;
      $display("FAIL run_timeout: %0d/%0d txns left after %0d cycles, want 0", q0.size(), q1.size(), budget);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int base;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'd0; m0_wdata = 32'h1111_0000;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'd1; m1_wdata = 32'h2222_0001;
    #3;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
          mem_addr !== '0 || mem_wdata !== '0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 ||
          m0_rdata !== '0 || m1_rdata !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs: gnt=%b%b en=%b rv=%b%b busy=%b, want all 0",
                 m1_gnt, m0_gnt, mem_en, m1_rvalid, m0_rvalid, busy);
      end
`ifdef DMEM_ARB_PERF_EN
      total++;
      if (m0_stall_cnt !== 32'd0 || m1_stall_cnt !== 32'd0) begin
        bad++;
        $display("FAIL reset_stall: %0d %0d want 0 0", m0_stall_cnt, m1_stall_cnt);
      end
`endif
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    q0.push_back('{1'b1, 4'd0, 32'h1111_0000});
    q1.push_back('{1'b1, 4'd1, 32'h2222_0001});
    base = gnt_log.size();
    run(8);
    total++;
    if (gnt_log.size() < base + 2 || gnt_log[base] !== 0 || gnt_log[base+1] !== 1) begin
      bad++;
      $display("FAIL first_tie: log starts %0d,%0d want 0,1",
               gnt_log.size() > base ? gnt_log[base] : -9, gnt_log.size() > base + 1 ? gnt_log[base+1] : -9);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    int base = gnt_log.size();
    for (int i = 0; i < 16; i++) q1.push_back('{1'b1, 4'(i), $urandom});
    run(40);
    total++;
    if (gnt_log.size() - base !== 16) begin
      bad++;
      $display("FAIL b2b_len: %0d grants want 16", gnt_log.size() - base);
    end
    for (int i = 0; i < 16 && base + i < gnt_log.size(); i++) begin
      total++;
      if (gnt_log[base+i] !== 1) begin
        bad++;
        $display("FAIL b2b_gnt[%0d]: got %0d want 1", i, gnt_log[base+i]);
      end
    end
    idle(1);
  endtask

  task automatic test_arb_reads();
    int base = gnt_log.size();
    int want [16] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1};
    for (int i = 0; i < 8; i++) begin
      q0.push_back('{1'b0, 4'(i), '0});
      q1.push_back('{1'b0, 4'(i + 8), '0});
    end
    run(40);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (base + i >= gnt_log.size() || gnt_log[base+i] !== want[i]) begin
        bad++;
        $display("FAIL arb_seq[%0d]: got %0d want %0d", i,
                 base + i < gnt_log.size() ? gnt_log[base+i] : -9, want[i]);
      end
    end
    idle(1);
  endtask

  task automatic test_write_read();
    int base;
    q0.push_back('{1'b1, 4'd2, 32'd68});
    q0.push_back('{1'b0, 4'd2, '0});
    run(8);
    @(negedge clk);
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'd68 || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_same: m0 rv=%b rd=%0d m1 rv=%b want 1 68 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    idle(1);
    base = gnt_log.size();
    q0.push_back('{1'b0, 4'd5, '0});
    q1.push_back('{1'b1, 4'd5, 32'h0000_ABCD});
    run(8);
    @(negedge clk);
    total++;
    if (gnt_log.size() < base + 2 || gnt_log[base] !== 1 || gnt_log[base+1] !== 0 ||
        m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_ABCD) begin
      bad++;
      $display("FAIL wr_rd_cross: m0 rv=%b rd=%h want 1 0000abcd after grants m1,m0", m0_rvalid, m0_rdata);
    end
    idle(1);
  endtask

  task automatic test_rst_mid_read();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'd3; m1_wdata = '0;
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rst_rd_gnt: m1_gnt=%b want 1", m1_gnt);
    end
    #1;
    rst = 1'b0;
    m1_req = 1'b0; m1_addr = '0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_rd_drop: m1_rvalid=%b busy=%b want 0 0", m1_rvalid, busy);
      end
    end
    idle(1);
  endtask

  task automatic test_saturate();
    int base = gnt_log.size();
    for (int i = 0; i < 6; i++) q1.push_back('{1'b1, 4'(8 + i), $urandom});
    run(20);
    total++;
    if (gnt_log.size() - base !== 6) begin
      bad++;
      $display("FAIL sat_len: %0d grants want 6", gnt_log.size() - base);
    end
    for (int i = 0; i < 6 && base + i < gnt_log.size(); i++) begin
      total++;
      if (gnt_log[base+i] !== 1) begin
        bad++;
        $display("FAIL sat_gnt[%0d]: got %0d want 1", i, gnt_log[base+i]);
      end
    end
    idle(1);
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic test_perf();
    int base;
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    total++;
    if (m0_stall_cnt !== 32'd0 || m1_stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_clr: %0d %0d want 0 0", m0_stall_cnt, m1_stall_cnt);
    end
    base = gnt_log.size();
    for (int i = 0; i < 4; i++) q0.push_back('{1'b0, 4'(i), '0});
    q1.push_back('{1'b0, 4'd9, '0});
    run(20);
    total++;
    if (m1_stall_cnt !== 32'd4 || m0_stall_cnt !== 32'd0) begin
      bad++;
      $display("FAIL perf_stall: m0=%0d m1=%0d want 0 4", m0_stall_cnt, m1_stall_cnt);
    end
    total++;
    if (gnt_log.size() < base + 5 || gnt_log[base+3] !== 0 || gnt_log[base+4] !== 1) begin
      bad++;
      $display("FAIL perf_seq: grant count %0d want burst of 4 m0 then m1", gnt_log.size() - base);
    end
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_arb_reads();
    test_write_read();
    test_rst_mid_read();
    test_saturate();
`ifdef DMEM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule
